// File: rtl/mantissa_oaud_seq_pkg.sv
// Shared types and constants for the mantissa divider family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oaum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Exponent-adjust codes returned alongside the quotient fraction.
    localparam logic [1:0] SHIFT_DEC  = 2'b00;
    localparam logic [1:0] SHIFT_NONE = 2'b01;
    localparam logic [1:0] SHIFT_INC  = 2'b10;

    // Remainder width: 1.X < 2 * 1.Y keeps R < 2V, so W+3 bits never overflow.
    function automatic int rem_width(input int w);
        return w + 3;
    endfunction

endpackage

// File: rtl/mantissa_oaud_seq_norm_round.sv
// Normalizes a raw quotient in (0.5, 2) to a W-bit fraction plus exponent adjust.
// Latency: combinational.  Backpressure: none.
// MANTISSA_OAUD_ROUND_EN adds round-to-nearest-even with guard/sticky.
module oaud_norm_round
    import oaum_pkg::*;
#(
    parameter int W = 23
) (
    input  logic [W+2:0] q_i,       // q_i[W+2] has weight 2^0, q_i[0] weight 2^-(W+2)
    input  logic         rem_nz_i,  // final remainder non-zero
    output logic [W-1:0] mant_o,
    output logic [1:0]   shift_o
);

`ifdef MANTISSA_OAUD_ROUND_EN
    logic [W-1:0] frac;
    logic [W:0]   sum;
    logic         guard;
    logic         sticky;
    logic [1:0]   base_shift;

    // Pick the fraction window, then round to nearest even; carry-out renormalizes.
    always_comb begin
        frac       = '0;
        guard      = 1'b0;
        sticky     = 1'b0;
        base_shift = SHIFT_NONE;
        sum        = '0;
        mant_o     = '0;
        shift_o    = SHIFT_NONE;
        if (q_i[W+2]) begin
            frac       = q_i[W+1:2];
            guard      = q_i[1];
            sticky     = q_i[0] | rem_nz_i;
            base_shift = SHIFT_NONE;
        end else begin
            frac       = q_i[W:1];
            guard      = q_i[0];
            sticky     = rem_nz_i;
            base_shift = SHIFT_DEC;
        end
        sum = {1'b0, frac} + {{W{1'b0}}, guard & (sticky | frac[0])};
        if (sum[W]) begin
            mant_o  = '0;
            shift_o = (base_shift == SHIFT_NONE) ? SHIFT_INC : SHIFT_NONE;
        end else begin
            mant_o  = sum[W-1:0];
            shift_o = base_shift;
        end
    end
`else
    // Truncating build: guard position and remainder carry no information.
    logic unused_bits;
    assign unused_bits = q_i[0] ^ rem_nz_i;

    // Select the fraction window according to the integer bit of the quotient.
    always_comb begin
        mant_o  = '0;
        shift_o = SHIFT_NONE;
        if (q_i[W+2]) begin
            mant_o  = q_i[W+1:2];
            shift_o = SHIFT_NONE;
        end else begin
            mant_o  = q_i[W:1];
            shift_o = SHIFT_DEC;
        end
    end
`endif

endmodule

// File: rtl/mantissa_oaud_seq.sv
// Iterative restoring divider (1.X)/(1.Y), one quotient bit per cycle; optional MANTISSA_OAUD_ROUND_EN.
// Latency: ITER_CNT+1 cycles accept-to-Out_Valid (ITER_CNT+2 with rounding).
// Backpressure: result held in DONE until Out_Ready; In_Ready low while BUSY/DONE.
module mantissa_oaud_seq
    import oaum_pkg::*;
#(
    parameter int BASELINE       = 23,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ITER_CNT       = MANTISSA_WIDTH + 2   // legal 2..MANTISSA_WIDTH+2
) (
    input  logic                                   Clk,
    input  logic                                   Rst,
    input  logic                                   In_Valid,
    output logic                                   In_Ready,
    input  logic [BASELINE-1:BASELINE-MANTISSA_WIDTH] Mantissa_X,
    input  logic [BASELINE-1:BASELINE-MANTISSA_WIDTH] Mantissa_Y,
    output logic                                   Out_Valid,
    input  logic                                   Out_Ready,
    output logic [BASELINE-1:BASELINE-MANTISSA_WIDTH] Mantissa_Out,
    output logic [1:0]                             Shift
);

    localparam int W  = MANTISSA_WIDTH;
    localparam int RW = rem_width(W);
    localparam int QW = W + 3;
    localparam int CW = $clog2(W + 4);
`ifdef MANTISSA_OAUD_ROUND_EN
    localparam int NIT = ITER_CNT + 1;   // extra guard iteration
`else
    localparam int NIT = ITER_CNT;
`endif
    localparam logic [CW-1:0] LAST = CW'(NIT);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   r_q, r_d;
    logic [RW-1:0]   v_q, v_d;
    logic [QW-1:0]   q_q, q_d;
    logic [W-1:0]    mant_q, mant_d;
    logic [1:0]      shift_q, shift_d;

    logic            ge;
    logic [RW-1:0]   r_sub;
    logic [QW-1:0]   q_aligned;
    logic [W-1:0]    norm_mant;
    logic [1:0]      norm_shift;

    // Quotient bits are shifted in at the LSB; after NIT iterations Q[0] sits at bit NIT-1,
    // so a constant left shift places it at the MSB and zero-fills the unreached bits.
    assign q_aligned = q_q << (QW - NIT);

    oaud_norm_round #(.W(W)) u_norm (
        .q_i      (q_aligned),
        .rem_nz_i (|r_q),
        .mant_o   (norm_mant),
        .shift_o  (norm_shift)
    );

    assign Mantissa_Out = mant_q;
    assign Shift        = shift_q;

    // Next-state, datapath step and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        v_d       = v_q;
        q_d       = q_q;
        mant_d    = mant_q;
        shift_d   = shift_q;
        In_Ready  = (state_q == IDLE);
        Out_Valid = (state_q == DONE);
        ge        = (r_q >= v_q);
        r_sub     = ge ? (r_q - v_q) : r_q;
        case (state_q)
            IDLE: begin
                if (In_Valid) begin
                    r_d     = {2'b00, 1'b1, Mantissa_X};
                    v_d     = {2'b00, 1'b1, Mantissa_Y};
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST) begin
                    mant_d  = norm_mant;
                    shift_d = norm_shift;
                    state_d = DONE;
                end else begin
                    q_d   = {q_q[QW-2:0], ge};
                    r_d   = r_sub << 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (Out_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            v_q     <= '0;
            q_q     <= '0;
            mant_q  <= '0;
            shift_q <= SHIFT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            v_q     <= v_d;
            q_q     <= q_d;
            mant_q  <= mant_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_mantissa_oaud_seq.sv
// Bench for mantissa_oaud_seq: full-length and ITER_CNT=10 instances against an arithmetic model.
// Latency: checks exact accept-to-valid cycle count.
// Backpressure: holds Out_Ready low and checks result stability and In_Ready.
module tb_mantissa_oaud_seq;

    localparam int W = 23;
`ifdef MANTISSA_OAUD_ROUND_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv   [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic [W-1:0] mx   [2];
    logic [W-1:0] my   [2];
    logic [W-1:0] mo   [2];
    logic [1:0]   sh   [2];

    int vectors = 0;
    int errs    = 0;

    mantissa_oaud_seq u_full (
        .Clk(clk), .Rst(rst), .In_Valid(iv[0]), .In_Ready(ir[0]),
        .Mantissa_X(mx[0]), .Mantissa_Y(my[0]), .Out_Valid(ov[0]),
        .Out_Ready(ordy[0]), .Mantissa_Out(mo[0]), .Shift(sh[0])
    );

    mantissa_oaud_seq #(.ITER_CNT(10)) u_short (
        .Clk(clk), .Rst(rst), .In_Valid(iv[1]), .In_Ready(ir[1]),
        .Mantissa_X(mx[1]), .Mantissa_Y(my[1]), .Out_Valid(ov[1]),
        .Out_Ready(ordy[1]), .Mantissa_Out(mo[1]), .Shift(sh[1])
    );

    function automatic int iters(input int d);
        return (d == 0) ? W + 2 : 10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Quotient from integer division of the scaled significands, then normalized by value.
    function automatic void model(input int n, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] m, output logic [1:0] s);
        logic [63:0] a, b, qi, qf;
        a = {40'd0, 1'b1, x};
        b = {40'd0, 1'b1, y};
`ifdef MANTISSA_OAUD_ROUND_EN
        begin
            logic        g, st, up;
            logic [63:0] mm;
            qi = (a << n) / b;
            st = (((a << n) % b) != 0);
            qf = qi << (W + 2 - n);             // LSB weight 2^-(W+2)
            if (qf[W+2]) begin
                mm = (qf >> 2) & ((64'd1 << W) - 1);
                g  = qf[1];
                st = st | qf[0];
                s  = 2'b01;
            end else begin
                mm = (qf >> 1) & ((64'd1 << W) - 1);
                g  = qf[0];
                s  = 2'b00;
            end
            up = g & (st | mm[0]);
            mm = mm + {63'd0, up};
            if (mm == (64'd1 << W)) begin
                m = '0;
                s = (s == 2'b01) ? 2'b10 : 2'b01;
            end else begin
                m = mm[W-1:0];
            end
        end
`else
        qi = (a << (n - 1)) / b;
        qf = qi << (W + 2 - n);                 // LSB weight 2^-(W+1)
        if (qf[W+1]) begin
            m = qf[W:1];
            s = 2'b01;
        end else begin
            m = qf[W-1:0];
            s = 2'b00;
        end
`endif
    endfunction

    task automatic run_op(input int d, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
        logic [W-1:0] em;
        logic [1:0]   es;
        int           lat;
        model(iters(d), x, y, em, es);
        mx[d] = x;
        my[d] = y;
        iv[d] = 1'b1;
        chk("in_ready_idle", 32'(ir[d]), 32'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = 0;
        while (ov[d] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(iters(d) + 1 + EXTRA));
        chk("mant", 32'(mo[d]), 32'(em));
        chk("shift", 32'(sh[d]), 32'(es));
        if (hold > 0) begin
            iv[d] = 1'b1;
            mx[d] = ~x;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("bp_valid", 32'(ov[d]), 32'd1);
                chk("bp_in_ready", 32'(ir[d]), 32'd0);
                chk("bp_mant", 32'(mo[d]), 32'(em));
                chk("bp_shift", 32'(sh[d]), 32'(es));
            end
        end
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        iv[d]   = 1'b0;
        chk("release_in_ready", 32'(ir[d]), 32'd1);
        chk("release_valid", 32'(ov[d]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; mx[d] = '0; my[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 32'(ir[d]), 32'd1);
            chk("rst_valid", 32'(ov[d]), 32'd0);
            chk("rst_mant", 32'(mo[d]), 32'd0);
            chk("rst_shift", 32'(sh[d]), 32'd1);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, including mantissa extremes.
        run_op(0, 23'h000000, 23'h000000, 0);
        run_op(0, 23'h000000, 23'h400000, 0);
        run_op(0, 23'h400000, 23'h000000, 0);
        run_op(0, 23'h7FFFFF, 23'h000000, 0);
        run_op(0, 23'h7FFFFF, 23'h000001, 0);
        run_op(0, 23'h000000, 23'h7FFFFF, 0);
        run_op(0, 23'h123456, 23'h654321, 5);
        run_op(1, 23'h000000, 23'h400000, 0);
        run_op(1, 23'h7FFFFF, 23'h000000, 3);

        // Abort after seven iterations; a later operation must be unaffected.
        mx[0] = 23'h000000;
        my[0] = 23'h400000;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(ir[0]), 32'd1);
        chk("abort_valid", 32'(ov[0]), 32'd0);
        chk("abort_mant", 32'(mo[0]), 32'd0);
        chk("abort_shift", 32'(sh[0]), 32'd1);
        run_op(0, 23'h2AAAAA, 23'h155555, 0);

        // Random operands on both instances.
        for (int i = 0; i < 20; i++) begin
            run_op(0, 23'($urandom), 23'($urandom), (i % 4 == 0) ? 2 : 0);
        end
        for (int i = 0; i < 10; i++) begin
            run_op(1, 23'($urandom), 23'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
